// File: rtl/axi_ad7124_frame_writer.sv
// Gathers per-board TC/RTD byte streams from the AD7124 SPI engines and, once every
// enabled board holds a full sample set, writes one timestamped frame into a ping-pong BRAM bank.
module axi_ad7124_frame_writer #(
  parameter int          NUM_OF_BOARD    = 6,
  parameter int          BYTES_PER_BOARD = 32,
  parameter int          ADDR_WIDTH      = 13,
  parameter int          IRQ_CYCLES      = 256,
  parameter logic [31:0] FRAME_TYPE      = 32'h7124_0002
) (
  input  logic                      aclk,
  input  logic                      aresetn,
  input  logic [NUM_OF_BOARD-1:0]   tc_sdi_valid,
  input  logic [8*NUM_OF_BOARD-1:0] tc_sdi_data,
  input  logic [NUM_OF_BOARD-1:0]   tc_drdy,
  input  logic [NUM_OF_BOARD-1:0]   rtd_sdi_valid,
  input  logic [8*NUM_OF_BOARD-1:0] rtd_sdi_data,
  input  logic [NUM_OF_BOARD-1:0]   rtd_drdy,
  input  logic [NUM_OF_BOARD-1:0]   board_mask,
  input  logic [31:0]               ts_sec,
  input  logic [31:0]               ts_nsec,
  output logic                      bram_en,
  output logic [3:0]                bram_we,
  output logic [ADDR_WIDTH-1:0]     bram_addr,
  output logic [31:0]               bram_wrdata,
  output logic                      frame_bank,
  output logic                      irq,
  output logic [15:0]               dropped_cnt
);

  localparam int NCH       = 2 * NUM_OF_BOARD;
  localparam int WPB       = BYTES_PER_BOARD / 4;
  localparam int FRAME_LEN = 5 + NCH * WPB;
  localparam int CW        = $clog2(BYTES_PER_BOARD + 1);
  localparam int WW        = ADDR_WIDTH - 1;
  localparam int CHW       = $clog2(NCH);

  generate
    if (FRAME_LEN > (1 << WW)) begin : g_len_chk
      $error("frame length does not fit in one BRAM bank");
    end
    if ((BYTES_PER_BOARD % 4) != 0 || BYTES_PER_BOARD > 64) begin : g_bpb_chk
      $error("BYTES_PER_BOARD must be a multiple of 4 and at most 64");
    end
  endgenerate

  typedef enum logic {S_IDLE, S_WRITE} state_t;

  // Channels 0..N-1 are TC boards, N..2N-1 are RTD boards: this is also frame order.
  logic [NCH-1:0]             w_valid;
  logic [NCH-1:0]             w_drdy;
  logic [8*NCH-1:0]           w_data;
  logic [CW-1:0]              r_cnt [NCH];
  logic [8*BYTES_PER_BOARD-1:0] r_buf [NCH];
  logic [NCH-1:0]             r_ovf;
  logic [NCH-1:0]             w_full;
  logic [NCH-1:0]             w_ovf_set;
  logic [NUM_OF_BOARD-1:0]    w_brd_ok;
  logic                       w_ready;
  logic                       r_ready;
  logic                       r_ready_d;
  logic                       w_trig;
  logic                       w_start;

  state_t                     r_state;
  state_t                     w_state_next;
  logic [WW-1:0]              r_w;
  logic [WW-1:0]              w_w_next;
  logic                       w_last;

  logic [31:0]                r_ts_sec;
  logic [31:0]                r_ts_nsec;
  logic [NUM_OF_BOARD-1:0]    r_mask_lat;
  logic                       r_ovf_lat;
  logic [31:0]                r_seq;
  logic                       r_bank;
  logic                       r_frame_bank;
  logic                       r_done;
  logic                       r_irq;
  logic [15:0]                r_irq_cnt;
  logic [15:0]                r_dropped;

  logic                       r_bram_en;
  logic [3:0]                 r_bram_we;
  logic [ADDR_WIDTH-1:0]      r_bram_addr;
  logic [31:0]                r_bram_wrdata;
  logic                       w_bram_en_next;
  logic [3:0]                 w_bram_we_next;
  logic [ADDR_WIDTH-1:0]      w_bram_addr_next;
  logic [31:0]                w_bram_wrdata_next;

  logic [WW-1:0]              w_d;
  logic [CHW-1:0]             w_ch;
  logic [WW-1:0]              w_ws;
  logic [NCH-1:0]             w_ch_en;
  logic [31:0]                w_word;

  assign w_valid = {rtd_sdi_valid, tc_sdi_valid};
  assign w_drdy  = {rtd_drdy, tc_drdy};
  assign w_data  = {rtd_sdi_data, tc_sdi_data};

  genvar gi;
  generate
    for (gi = 0; gi < NCH; gi++) begin : g_ch
      assign w_full[gi]    = (r_cnt[gi] == CW'(BYTES_PER_BOARD));
      assign w_ovf_set[gi] = w_valid[gi] & ~w_drdy[gi] & w_full[gi];
    end
    for (gi = 0; gi < NUM_OF_BOARD; gi++) begin : g_brd
      assign w_brd_ok[gi] = ~board_mask[gi] | (w_full[gi] & w_full[gi+NUM_OF_BOARD]);
    end
  endgenerate

  assign w_ready = (|board_mask) & (&w_brd_ok);
  assign w_trig  = r_ready & ~r_ready_d;
  assign w_start = (r_state == S_IDLE) & w_trig;

  // drdy wins over a coincident valid; that byte is dropped.
  always_ff @(posedge aclk) begin
    if (!aresetn) begin
      for (int c = 0; c < NCH; c++) begin
        r_cnt[c] <= '0;
        r_buf[c] <= '0;
      end
      r_ovf <= '0;
    end else begin
      for (int c = 0; c < NCH; c++) begin
        if (w_drdy[c]) begin
          r_cnt[c] <= '0;
        end else if (w_valid[c] && (r_cnt[c] < CW'(BYTES_PER_BOARD))) begin
          r_buf[c][8*int'(r_cnt[c]) +: 8] <= w_data[8*c +: 8];
          r_cnt[c] <= r_cnt[c] + 1'b1;
        end
      end
      r_ovf <= (r_ovf & ~{NCH{w_start}}) | w_ovf_set;
    end
  end

  assign w_d     = r_w - WW'(5);
  assign w_ch    = CHW'(w_d / WW'(WPB));
  assign w_ws    = w_d % WW'(WPB);
  assign w_ch_en = {r_mask_lat, r_mask_lat};

  always_comb begin
    w_word = 32'h0;
    case (r_w)
      WW'(0):  w_word = FRAME_TYPE;
      WW'(1):  w_word = r_seq;
      WW'(2):  w_word = r_ts_sec;
      WW'(3):  w_word = r_ts_nsec;
      WW'(4):  w_word = {15'b0, r_ovf_lat, 16'(r_mask_lat)};
      default: begin
        if (w_ch_en[w_ch]) begin
          for (int k = 0; k < 4; k++) begin
            w_word[31-8*k -: 8] = r_buf[w_ch][8*(4*int'(w_ws)+k) +: 8];
          end
        end
      end
    endcase
  end

  always_comb begin
    w_state_next       = r_state;
    w_w_next           = r_w;
    w_last             = 1'b0;
    w_bram_en_next     = 1'b0;
    w_bram_we_next     = 4'h0;
    w_bram_addr_next   = '0;
    w_bram_wrdata_next = 32'h0;
    case (r_state)
      S_IDLE: begin
        if (w_trig) begin
          w_state_next = S_WRITE;
          w_w_next     = '0;
        end
      end
      S_WRITE: begin
        w_bram_en_next     = 1'b1;
        w_bram_we_next     = 4'hF;
        w_bram_addr_next   = {r_bank, r_w};
        w_bram_wrdata_next = w_word;
        if (r_w == WW'(FRAME_LEN - 1)) begin
          w_state_next = S_IDLE;
          w_last       = 1'b1;
        end else begin
          w_w_next = r_w + 1'b1;
        end
      end
      default: w_state_next = S_IDLE;
    endcase
  end

  always_ff @(posedge aclk) begin
    if (!aresetn) begin
      r_state <= S_IDLE;
      r_w     <= '0;
    end else begin
      r_state <= w_state_next;
      r_w     <= w_w_next;
    end
  end

  always_ff @(posedge aclk) begin
    if (!aresetn) begin
      r_ready       <= 1'b0;
      r_ready_d     <= 1'b0;
      r_ts_sec      <= '0;
      r_ts_nsec     <= '0;
      r_mask_lat    <= '0;
      r_ovf_lat     <= 1'b0;
      r_seq         <= '0;
      r_bank        <= 1'b0;
      r_frame_bank  <= 1'b0;
      r_done        <= 1'b0;
      r_irq         <= 1'b0;
      r_irq_cnt     <= '0;
      r_dropped     <= '0;
      r_bram_en     <= 1'b0;
      r_bram_we     <= 4'h0;
      r_bram_addr   <= '0;
      r_bram_wrdata <= '0;
    end else begin
      r_ready   <= w_ready;
      r_ready_d <= r_ready;
      if (w_start) begin
        r_ts_sec   <= ts_sec;
        r_ts_nsec  <= ts_nsec;
        r_mask_lat <= board_mask;
        r_ovf_lat  <= |r_ovf;
      end
      if ((r_state == S_WRITE) && w_trig && (r_dropped != 16'hFFFF)) begin
        r_dropped <= r_dropped + 16'd1;
      end
      if (w_last) begin
        r_bank       <= ~r_bank;
        r_frame_bank <= r_bank;
        r_seq        <= r_seq + 32'd1;
      end
      r_done <= w_last;
      // A frame finishing while irq is still high restarts the pulse.
      if (r_done) begin
        r_irq     <= 1'b1;
        r_irq_cnt <= 16'(IRQ_CYCLES - 1);
      end else if (r_irq_cnt != 16'd0) begin
        r_irq_cnt <= r_irq_cnt - 16'd1;
      end else begin
        r_irq <= 1'b0;
      end
      r_bram_en     <= w_bram_en_next;
      r_bram_we     <= w_bram_we_next;
      r_bram_addr   <= w_bram_addr_next;
      r_bram_wrdata <= w_bram_wrdata_next;
    end
  end

  assign bram_en     = r_bram_en;
  assign bram_we     = r_bram_we;
  assign bram_addr   = r_bram_addr;
  assign bram_wrdata = r_bram_wrdata;
  assign frame_bank  = r_frame_bank;
  assign irq         = r_irq;
  assign dropped_cnt = r_dropped;

endmodule

// File: tb/tb_axi_ad7124_frame_writer.sv
// Directed sequence of frames with random payload bytes, checked word by word against
// a frame image built from the byte-level model held in the bench.
module tb_axi_ad7124_frame_writer;
  localparam int          N   = 6;
  localparam int          BPB = 32;
  localparam int          AW  = 13;
  localparam int          IRQ = 256;
  localparam logic [31:0] FT  = 32'h7124_0002;
  localparam int          WPB = BPB / 4;
  localparam int          L   = 5 + 2 * N * WPB;

  logic            aclk;
  logic            aresetn;
  logic [N-1:0]    tc_sdi_valid, tc_drdy, rtd_sdi_valid, rtd_drdy, board_mask;
  logic [8*N-1:0]  tc_sdi_data, rtd_sdi_data;
  logic [31:0]     ts_sec, ts_nsec;
  logic            bram_en;
  logic [3:0]      bram_we;
  logic [AW-1:0]   bram_addr;
  logic [31:0]     bram_wrdata;
  logic            frame_bank;
  logic            irq;
  logic [15:0]     dropped_cnt;

  axi_ad7124_frame_writer #(
    .NUM_OF_BOARD(N), .BYTES_PER_BOARD(BPB), .ADDR_WIDTH(AW),
    .IRQ_CYCLES(IRQ), .FRAME_TYPE(FT)
  ) dut (
    .aclk(aclk), .aresetn(aresetn),
    .tc_sdi_valid(tc_sdi_valid), .tc_sdi_data(tc_sdi_data), .tc_drdy(tc_drdy),
    .rtd_sdi_valid(rtd_sdi_valid), .rtd_sdi_data(rtd_sdi_data), .rtd_drdy(rtd_drdy),
    .board_mask(board_mask), .ts_sec(ts_sec), .ts_nsec(ts_nsec),
    .bram_en(bram_en), .bram_we(bram_we), .bram_addr(bram_addr), .bram_wrdata(bram_wrdata),
    .frame_bank(frame_bank), .irq(irq), .dropped_cnt(dropped_cnt)
  );

  initial aclk = 1'b0;
  always #5 aclk = ~aclk;

  int checks = 0;
  int failures = 0;

  // Channel c < N is TC board c, otherwise RTD board c-N.
  logic [7:0]    m_byte [2*N][BPB];
  logic [AW-1:0] q_addr [$];
  logic [31:0]   q_data [$];
  logic [3:0]    q_we [$];
  int            irq_pulses [$];
  int            irq_run = 0;

  always @(negedge aclk) begin
    if (aresetn && bram_en) begin
      q_addr.push_back(bram_addr);
      q_data.push_back(bram_wrdata);
      q_we.push_back(bram_we);
    end
    if (irq) begin
      irq_run++;
    end else if (irq_run > 0) begin
      irq_pulses.push_back(irq_run);
      irq_run = 0;
    end
  end

  task automatic tick();
    @(posedge aclk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [31:0] exp_word(input int i, input int seq, input logic [N-1:0] mask,
                                           input bit ovf, input logic [31:0] sec, input logic [31:0] nsec);
    int d, ch, brd, k;
    if (i == 0) return FT;
    if (i == 1) return 32'(seq);
    if (i == 2) return sec;
    if (i == 3) return nsec;
    if (i == 4) return (ovf ? 32'h0001_0000 : 32'h0) | 32'(mask);
    d   = i - 5;
    ch  = d / WPB;
    k   = d % WPB;
    brd = (ch < N) ? ch : ch - N;
    if (!mask[brd]) return 32'h0;
    return {m_byte[ch][4*k], m_byte[ch][4*k+1], m_byte[ch][4*k+2], m_byte[ch][4*k+3]};
  endfunction

  task automatic fill(input logic [2*N-1:0] chm, input bit glitch, input bit extra);
    logic [7:0] b;
    tc_drdy = '1;
    rtd_drdy = '1;
    tc_sdi_valid = '0;
    rtd_sdi_valid = '0;
    if (glitch) begin
      tc_sdi_valid[0] = 1'b1;
      tc_sdi_data[7:0] = 8'hA5;
    end
    tick();
    tc_drdy = '0;
    rtd_drdy = '0;
    for (int j = 0; j < BPB; j++) begin
      tc_sdi_valid = '0;
      rtd_sdi_valid = '0;
      for (int c = 0; c < 2*N; c++) begin
        if (chm[c]) begin
          b = 8'($urandom);
          m_byte[c][j] = b;
          if (c < N) begin
            tc_sdi_valid[c] = 1'b1;
            tc_sdi_data[8*c +: 8] = b;
          end else begin
            rtd_sdi_valid[c-N] = 1'b1;
            rtd_sdi_data[8*(c-N) +: 8] = b;
          end
        end
      end
      tick();
    end
    tc_sdi_valid = '0;
    rtd_sdi_valid = '0;
    if (extra) begin
      tc_sdi_valid[3] = 1'b1;
      tc_sdi_data[31:24] = 8'h5A;
      tick();
      tc_sdi_valid = '0;
    end
  endtask

  task automatic wait_frame(input string tag, input int seq, input bit bank, input logic [N-1:0] mask,
                            input bit ovf, input logic [31:0] sec, input logic [31:0] nsec);
    int n;
    n = 0;
    while (irq_pulses.size() == 0 && n < 2000) begin
      tick();
      n++;
    end
    chk({tag, "_irq_seen"}, 64'(irq_pulses.size() != 0), 64'd1);
    if (irq_pulses.size() != 0) chk({tag, "_irq_len"}, 64'(irq_pulses[0]), 64'(IRQ));
    chk({tag, "_nwrites"}, 64'(q_addr.size()), 64'(L));
    for (int i = 0; i < L; i++) begin
      if (i < q_addr.size()) begin
        chk($sformatf("%s_addr%0d", tag, i), 64'(q_addr[i]), 64'((bank ? 4096 : 0) + i));
        chk($sformatf("%s_data%0d", tag, i), 64'(q_data[i]), 64'(exp_word(i, seq, mask, ovf, sec, nsec)));
        chk($sformatf("%s_we%0d", tag, i), 64'(q_we[i]), 64'h0F);
      end
    end
    chk({tag, "_frame_bank"}, 64'(frame_bank), 64'(bank));
    q_addr.delete();
    q_data.delete();
    q_we.delete();
    irq_pulses.delete();
  endtask

  initial begin
    logic [31:0] sec, nsec;
    int n;
    bit found;
    aresetn = 1'b0;
    tc_sdi_valid = '0; tc_drdy = '0; tc_sdi_data = '0;
    rtd_sdi_valid = '0; rtd_drdy = '0; rtd_sdi_data = '0;
    board_mask = 6'h3F;
    ts_sec = '0; ts_nsec = '0;
    repeat (3) tick();
    chk("rst_bram_en", 64'(bram_en), 64'd0);
    chk("rst_bram_we", 64'(bram_we), 64'd0);
    chk("rst_bram_addr", 64'(bram_addr), 64'd0);
    chk("rst_bram_wrdata", 64'(bram_wrdata), 64'd0);
    chk("rst_irq", 64'(irq), 64'd0);
    chk("rst_frame_bank", 64'(frame_bank), 64'd0);
    chk("rst_dropped", 64'(dropped_cnt), 64'd0);
    aresetn = 1'b1;
    tick();

    // A: full set, bank 0, sequence 0
    sec = $urandom; nsec = $urandom; ts_sec = sec; ts_nsec = nsec;
    fill('1, 1'b0, 1'b0);
    wait_frame("A", 0, 1'b0, 6'h3F, 1'b0, sec, nsec);
    chk("A_dropped", 64'(dropped_cnt), 64'd0);

    // B: bank 1, and a trigger forced in mid-write by toggling the mask
    sec = $urandom; nsec = $urandom; ts_sec = sec; ts_nsec = nsec;
    fill('1, 1'b0, 1'b0);
    n = 0;
    while (q_addr.size() == 0 && n < 50) begin
      tick();
      n++;
    end
    chk("B_write_start", 64'(q_addr.size() != 0), 64'd1);
    repeat (10) tick();
    board_mask = 6'h00;
    repeat (2) tick();
    board_mask = 6'h3F;
    wait_frame("B", 1, 1'b1, 6'h3F, 1'b0, sec, nsec);
    chk("B_dropped", 64'(dropped_cnt), 64'd1);

    // C: boards 0..1 only, with drdy+valid coincident on TC0
    board_mask = 6'h03;
    sec = $urandom; nsec = $urandom; ts_sec = sec; ts_nsec = nsec;
    fill(12'h0C3, 1'b1, 1'b0);
    wait_frame("C", 2, 1'b0, 6'h03, 1'b0, sec, nsec);
    chk("C_dropped", 64'(dropped_cnt), 64'd1);

    // D: 33rd byte on TC3 flags overflow
    board_mask = 6'h3F;
    sec = $urandom; nsec = $urandom; ts_sec = sec; ts_nsec = nsec;
    fill('1, 1'b0, 1'b1);
    wait_frame("D", 3, 1'b1, 6'h3F, 1'b1, sec, nsec);

    // E: overflow flag cleared again
    sec = $urandom; nsec = $urandom; ts_sec = sec; ts_nsec = nsec;
    fill('1, 1'b0, 1'b0);
    wait_frame("E", 4, 1'b0, 6'h3F, 1'b0, sec, nsec);

    // Reset in the middle of a frame
    fill('1, 1'b0, 1'b0);
    found = 1'b0;
    for (int i = 0; i < 400; i++) begin
      tick();
      if (bram_en && bram_addr[AW-2:0] == 12'd50) begin
        found = 1'b1;
        break;
      end
    end
    chk("R_reached_w50", 64'(found), 64'd1);
    aresetn = 1'b0;
    tick();
    chk("R_bram_en", 64'(bram_en), 64'd0);
    chk("R_bram_we", 64'(bram_we), 64'd0);
    tick();
    aresetn = 1'b1;
    repeat (300) tick();
    chk("R_no_irq", 64'(irq_pulses.size()), 64'd0);
    chk("R_frame_bank", 64'(frame_bank), 64'd0);
    chk("R_dropped", 64'(dropped_cnt), 64'd0);
    q_addr.delete();
    q_data.delete();
    q_we.delete();
    irq_pulses.delete();

    // F: restarts at bank 0, sequence 0
    sec = $urandom; nsec = $urandom; ts_sec = sec; ts_nsec = nsec;
    fill('1, 1'b0, 1'b0);
    wait_frame("F", 0, 1'b0, 6'h3F, 1'b0, sec, nsec);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule

// File: doc/axi_ad7124_frame_writer.md
Name: axi_ad7124_frame_writer

Overview:
Collects per-board TC and RTD byte streams from NUM_OF_BOARD AD7124 SPI engines into local byte buffers. When all enabled boards have a complete sample set, it writes one timestamped frame into a ping-pong BRAM region and raises an interrupt. It sits between the AD7124 SPI engines and an AXI BRAM controller read by the PS. It adds board masking, double-banking, overflow and dropped-frame accounting, and a per-frame status word.

Parameters:
NUM_OF_BOARD, 6, number of boards; each board has one TC and one RTD channel.
BYTES_PER_BOARD, 32, bytes per channel per sample set; multiple of 4, max 64.
ADDR_WIDTH, 13, BRAM word-address width; MSB selects the bank.
IRQ_CYCLES, 256, irq pulse width in aclk cycles, 1..65535.
FRAME_TYPE, 32'h7124_0002, constant written as frame word 0.

Ports:
aclk  in  1  clock; bram_clk is aclk.
aresetn  in  1  synchronous active-low reset.
tc_sdi_valid  in  NUM_OF_BOARD  per-board TC byte strobe.
tc_sdi_data  in  8*NUM_OF_BOARD  TC bytes; board i at [8i+7:8i].
tc_drdy  in  NUM_OF_BOARD  TC start-of-sample-set pulse.
rtd_sdi_valid, rtd_sdi_data, rtd_drdy  in  same widths  RTD equivalents.
board_mask  in  NUM_OF_BOARD  1 = board enabled; sampled at trigger.
ts_sec, ts_nsec  in  32 each  free-running timestamp.
bram_en  out  1  BRAM enable.
bram_we  out  4  byte write enables.
bram_addr  out  ADDR_WIDTH  word address.
bram_wrdata  out  32  write data.
frame_bank  out  1  bank holding the last completed frame.
irq  out  1  frame-done pulse.
dropped_cnt  out  16  triggers lost while busy; saturates at 16'hFFFF.

Behaviour:
- Reset: all counters, buffers, flags, dropped_cnt and sequence are 0. bram_en, bram_we, bram_addr, bram_wrdata, irq and frame_bank are 0. State is IDLE.
- Per-channel counter cnt (0..BYTES_PER_BOARD):
  - drdy sets cnt to 0; drdy takes priority over a simultaneous valid, and that byte is discarded.
  - valid with cnt < BYTES_PER_BOARD stores the byte at index cnt, then cnt increments.
  - valid with cnt == BYTES_PER_BOARD discards the byte and sets that channel's sticky ovf flag.
- Channel complete: cnt == BYTES_PER_BOARD.
- ready: every board enabled in board_mask has both its TC and RTD channels complete. board_mask == 0 means never ready.
- Trigger is the rising edge of registered ready, so a frame starts 2 cycles after the last byte.
- FSM IDLE -> WRITE -> IDLE:
  - Trigger in IDLE: latch ts_sec, ts_nsec, board_mask and the OR of all ovf flags; clear all ovf flags; go to WRITE with word index w=0.
  - WRITE issues one word per cycle: bram_en=1, bram_we=4'hF, bram_addr = {bank, w}, zero-extended to ADDR_WIDTH-1 bits below the bank bit.
  - Frame length L = 5 + 2*NUM_OF_BOARD*BYTES_PER_BOARD/4. The default is 101.
  - After w = L-1: toggle bank, set frame_bank to the bank just written, increment sequence (wraps 2^32), return to IDLE, start irq.
- Frame words:
  - 0: FRAME_TYPE.
  - 1: sequence.
  - 2: latched ts_sec.
  - 3: latched ts_nsec.
  - 4: status = {15'b0, ovf_any, 16'(latched mask)}.
  - Then TC words for board 0..N-1 (BYTES_PER_BOARD/4 each), then RTD words in the same order.
  - Within a word, byte j of the channel goes to bits [31-8*(j%4) -: 8].
  - Masked-off boards write 32'h0.
- Bytes arriving during WRITE still land in the buffers. The software frame rate guarantees drdy does not precede WRITE completion; the block does not shadow-copy.
- Trigger during WRITE is not queued: dropped_cnt increments.
- bram outputs are registered. In IDLE, bram_en=0, bram_we=0, bram_addr=0.
- irq goes high the cycle after the final write and stays high exactly IRQ_CYCLES cycles.
  - A new frame completing while irq is high restarts the count.
- Reset mid-WRITE: abort immediately, clear all outputs next edge, bank returns to 0.
- Constraints: L <= 2^(ADDR_WIDTH-1); elaboration error otherwise.

Test Plan:
- Full set, default params: drdy then 32 bytes on all 12 channels. Expect 101 writes at addr 0..100. Word 0 = 32'h7124_0002, word 1 = 0. Word 5 = bytes 0..3 of TC0 big-endian, word 53 = RTD0 bytes 0..3. irq high 256 cycles. frame_bank=0.
- Second frame: words written at addr 4096..4196; word 1 = 1; frame_bank=1. Third frame returns to addr 0.
- board_mask=6'b000011 with only boards 0..1 filled: frame triggers. Status word = 32'h0000_0003. Board 2..5 words = 0.
- 33 bytes on TC3: byte 33 ignored. Status bit16 = 1 in the next frame only; the following frame has bit16 = 0.
- Second trigger forced 10 cycles into WRITE: dropped_cnt = 1, frame unaffected. Same-cycle drdy and valid on a channel leaves cnt = 0.
- aresetn low at w=50: bram_en=0 the next cycle, no irq. Next frame writes at addr 0 with sequence 0.
